// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared defaults, source encoding and CDB payload widths for the CDB arbiter
package cdb_arbiter_pkg;
  localparam int ROB_BIT_DEF = 4;
  localparam int DAT_W_DEF = 32;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;
  localparam int CBR_W = 1;
  function automatic int payload_w(input int rob_bit, input int dat_w);
    return rob_bit + 2 * dat_w + CBR_W;
  endfunction
endpackage

// File: rtl/cdb_arb_fifo.sv
// cdb_arb_fifo: QD-deep result FIFO with push, pop and flush
// Ports: clk, rst (async active-low), en (clock enable), flush (clears all entries),
//        push/din (enqueue when rdy), pop (dequeue head when non-empty),
//        head (oldest entry), empty, rdy (count != QD).
module cdb_arb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int W = payload_w(ROB_BIT_DEF, DAT_W_DEF),
  parameter int QD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         rdy
);
  localparam int AW = $clog2(QD);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [QD];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign rdy = cnt != CW'(QD);
  assign empty = cnt == '0;
  assign head = mem[rd];
  assign do_push = en && !flush && push && rdy;
  assign do_pop = en && !flush && pop && !empty;
  // QD is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else if (en) begin
      wr <= flush ? '0 : wr + AW'(do_push);
      rd <= flush ? '0 : rd + AW'(do_pop);
      cnt <= flush ? '0 : cnt + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the CDB between the ALU and LSB load results
// Ports: clk, rst (async active-low), en (global clock enable), flush_i (misprediction flush),
//        alu_* (ALU result push + alu_rdy_o), lsb_* (load result push + lsb_rdy_o),
//        cdb_* (registered broadcast; cdb_src_o 0 = ALU, 1 = LSB).
// Optional: define CDB_ARB_BYPASS_EN to let an empty source's incoming result broadcast directly.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_BIT = ROB_BIT_DEF,
  parameter int DAT_W = DAT_W_DEF,
  parameter int QD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush_i,
  input  logic               alu_en_i,
  input  logic [ROB_BIT-1:0] alu_q_i,
  input  logic [DAT_W-1:0]   alu_v_i,
  input  logic               alu_cbr_i,
  input  logic [DAT_W-1:0]   alu_cbt_i,
  output logic               alu_rdy_o,
  input  logic               lsb_en_i,
  input  logic [ROB_BIT-1:0] lsb_q_i,
  input  logic [DAT_W-1:0]   lsb_v_i,
  output logic               lsb_rdy_o,
  output logic               cdb_en_o,
  output logic [ROB_BIT-1:0] cdb_q_o,
  output logic [DAT_W-1:0]   cdb_v_o,
  output logic               cdb_cbr_o,
  output logic [DAT_W-1:0]   cdb_cbt_o,
  output logic               cdb_src_o
);
  localparam int PW = payload_w(ROB_BIT, DAT_W);
  logic [PW-1:0] alu_din, lsb_din, alu_head, lsb_head, win;
  logic alu_empty, lsb_empty, alu_c, lsb_c, g_alu, g_lsb, alu_push, lsb_push, last;
  assign alu_din = {alu_q_i, alu_v_i, alu_cbr_i, alu_cbt_i};
  assign lsb_din = {lsb_q_i, lsb_v_i, 1'b0, {DAT_W{1'b0}}};
`ifdef CDB_ARB_BYPASS_EN
  // an empty source with a valid push competes with its incoming result, which skips the FIFO if it wins
  assign alu_c = !alu_empty || alu_en_i;
  assign lsb_c = !lsb_empty || lsb_en_i;
  assign alu_push = alu_en_i && !(g_alu && alu_empty);
  assign lsb_push = lsb_en_i && !(g_lsb && lsb_empty);
  assign win = g_alu ? (alu_empty ? alu_din : alu_head) : (lsb_empty ? lsb_din : lsb_head);
`else
  assign alu_c = !alu_empty;
  assign lsb_c = !lsb_empty;
  assign alu_push = alu_en_i;
  assign lsb_push = lsb_en_i;
  assign win = g_alu ? alu_head : lsb_head;
`endif
  // on a tie the source not granted last wins
  assign g_alu = alu_c && (!lsb_c || last == SRC_LSB);
  assign g_lsb = lsb_c && !g_alu;
  cdb_arb_fifo #(.W(PW), .QD(QD)) u_alu_fifo (
    .clk(clk), .rst(rst), .en(en), .flush(flush_i), .push(alu_push), .pop(g_alu),
    .din(alu_din), .head(alu_head), .empty(alu_empty), .rdy(alu_rdy_o)
  );
  cdb_arb_fifo #(.W(PW), .QD(QD)) u_lsb_fifo (
    .clk(clk), .rst(rst), .en(en), .flush(flush_i), .push(lsb_push), .pop(g_lsb),
    .din(lsb_din), .head(lsb_head), .empty(lsb_empty), .rdy(lsb_rdy_o)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last <= SRC_LSB;
      cdb_en_o <= 1'b0;
      {cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o} <= '0;
      cdb_src_o <= SRC_ALU;
    end else if (en) begin
      if (flush_i) begin
        last <= SRC_LSB;
        cdb_en_o <= 1'b0;
      end else begin
        cdb_en_o <= g_alu || g_lsb;
        if (g_alu || g_lsb) begin
          last <= g_lsb;
          cdb_src_o <= g_lsb;
          {cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o} <= win;
        end
      end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (default build)
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en, flush_i;
  logic alu_en_i, alu_cbr_i, alu_rdy_o;
  logic [3:0] alu_q_i, lsb_q_i, cdb_q_o;
  logic [31:0] alu_v_i, alu_cbt_i, lsb_v_i, cdb_v_o, cdb_cbt_o;
  logic lsb_en_i, lsb_rdy_o, cdb_en_o, cdb_cbr_o, cdb_src_o;
  int cmp = 0;
  int bad = 0;
  always #5 clk = ~clk;
  cdb_arbiter dut (
    .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
    .alu_en_i(alu_en_i), .alu_q_i(alu_q_i), .alu_v_i(alu_v_i), .alu_cbr_i(alu_cbr_i),
    .alu_cbt_i(alu_cbt_i), .alu_rdy_o(alu_rdy_o),
    .lsb_en_i(lsb_en_i), .lsb_q_i(lsb_q_i), .lsb_v_i(lsb_v_i), .lsb_rdy_o(lsb_rdy_o),
    .cdb_en_o(cdb_en_o), .cdb_q_o(cdb_q_o), .cdb_v_o(cdb_v_o), .cdb_cbr_o(cdb_cbr_o),
    .cdb_cbt_o(cdb_cbt_o), .cdb_src_o(cdb_src_o)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    en = 1'b1; flush_i = 1'b0;
    alu_en_i = 1'b0; alu_q_i = '0; alu_v_i = '0; alu_cbr_i = 1'b0; alu_cbt_i = '0;
    lsb_en_i = 1'b0; lsb_q_i = '0; lsb_v_i = '0;
  endtask
  task automatic do_reset;
    idle_in();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask
  task automatic alu(input logic [3:0] q, input logic [31:0] v);
    alu_en_i = 1'b1; alu_q_i = q; alu_v_i = v; alu_cbr_i = 1'b0; alu_cbt_i = '0;
  endtask
  task automatic lsb(input logic [3:0] q, input logic [31:0] v);
    lsb_en_i = 1'b1; lsb_q_i = q; lsb_v_i = v;
  endtask
  task automatic expect_bc(input string nm, input logic e, input logic [3:0] q, input logic s);
    cmp++; if (cdb_en_o !== e) begin bad++; $display("FAIL %s en got %b want %b", nm, cdb_en_o, e); end
    if (e) begin
      cmp++; if (cdb_q_o !== q) begin bad++; $display("FAIL %s q got %0d want %0d", nm, cdb_q_o, q); end
      cmp++; if (cdb_src_o !== s) begin bad++; $display("FAIL %s src got %b want %b", nm, cdb_src_o, s); end
    end
  endtask
  task automatic test_reset;
    idle_in();
    #1 rst = 1'b0;
    #2;
    cmp++; if (cdb_en_o !== 1'b0) begin bad++; $display("FAIL reset_en got %b want 0", cdb_en_o); end
    cmp++; if (cdb_q_o !== 4'd0 || cdb_v_o !== 32'd0) begin bad++; $display("FAIL reset_qv got %0h/%0h want 0/0", cdb_q_o, cdb_v_o); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp++; if (cdb_en_o !== 1'b0) begin bad++; $display("FAIL idle_en[%0d] got %b want 0", i, cdb_en_o); end
      cmp++; if ({alu_rdy_o, lsb_rdy_o} !== 2'b11) begin bad++; $display("FAIL idle_rdy[%0d] got %b want 11", i, {alu_rdy_o, lsb_rdy_o}); end
    end
  endtask
  task automatic test_single;
    do_reset();
    alu_en_i = 1'b1; alu_q_i = 4'd3; alu_v_i = 32'h12; alu_cbr_i = 1'b1; alu_cbt_i = 32'h100;
    step();
    idle_in();
    expect_bc("single_latency", 1'b0, 4'd0, 1'b0);
    step();
    expect_bc("single_bc", 1'b1, 4'd3, 1'b0);
    cmp++; if (cdb_v_o !== 32'h12) begin bad++; $display("FAIL single_v got %0h want 12", cdb_v_o); end
    cmp++; if (cdb_cbr_o !== 1'b1) begin bad++; $display("FAIL single_cbr got %b want 1", cdb_cbr_o); end
    cmp++; if (cdb_cbt_o !== 32'h100) begin bad++; $display("FAIL single_cbt got %0h want 100", cdb_cbt_o); end
    step();
    expect_bc("single_done", 1'b0, 4'd0, 1'b0);
    cmp++; if (cdb_q_o !== 4'd3) begin bad++; $display("FAIL single_hold_q got %0d want 3", cdb_q_o); end
  endtask
  task automatic test_tie;
    do_reset();
    alu(4'd1, 32'hA1);
    lsb(4'd2, 32'hB2);
    step();
    idle_in();
    step();
    expect_bc("tie_first", 1'b1, 4'd1, 1'b0);
    step();
    expect_bc("tie_second", 1'b1, 4'd2, 1'b1);
    cmp++; if (cdb_v_o !== 32'hB2 || cdb_cbr_o !== 1'b0 || cdb_cbt_o !== 32'd0) begin
      bad++; $display("FAIL tie_lsb_payload got %0h/%b/%0h want b2/0/0", cdb_v_o, cdb_cbr_o, cdb_cbt_o);
    end
    step();
    expect_bc("tie_idle", 1'b0, 4'd0, 1'b0);
  endtask
  task automatic test_back_to_back;
    do_reset();
    alu(4'd1, 32'h1); lsb(4'd5, 32'h5);
    step();
    expect_bc("b2b_e1", 1'b0, 4'd0, 1'b0);
    alu(4'd2, 32'h2); lsb(4'd6, 32'h6);
    step();
    expect_bc("b2b_e2", 1'b1, 4'd1, 1'b0);
    cmp++; if ({alu_rdy_o, lsb_rdy_o} !== 2'b10) begin bad++; $display("FAIL b2b_rdy_e2 got %b want 10", {alu_rdy_o, lsb_rdy_o}); end
    alu(4'd3, 32'h3); lsb(4'd7, 32'h7);
    step();
    expect_bc("b2b_e3", 1'b1, 4'd5, 1'b1);
    cmp++; if ({alu_rdy_o, lsb_rdy_o} !== 2'b01) begin bad++; $display("FAIL b2b_rdy_e3 got %b want 01", {alu_rdy_o, lsb_rdy_o}); end
    idle_in();
    alu(4'd4, 32'h4);
    step();
    idle_in();
    expect_bc("b2b_e4", 1'b1, 4'd2, 1'b0);
    step();
    expect_bc("b2b_e5", 1'b1, 4'd6, 1'b1);
    step();
    expect_bc("b2b_e6", 1'b1, 4'd3, 1'b0);
    step();
    expect_bc("b2b_e7", 1'b0, 4'd0, 1'b0);
  endtask
  task automatic test_flush;
    do_reset();
    alu(4'd1, 32'h1); lsb(4'd5, 32'h5);
    step();
    alu(4'd2, 32'h2); lsb(4'd6, 32'h6);
    step();
    expect_bc("flush_pre", 1'b1, 4'd1, 1'b0);
    idle_in();
    flush_i = 1'b1;
    lsb(4'd7, 32'h7);
    step();
    idle_in();
    expect_bc("flush_edge", 1'b0, 4'd0, 1'b0);
    cmp++; if ({alu_rdy_o, lsb_rdy_o} !== 2'b11) begin bad++; $display("FAIL flush_rdy got %b want 11", {alu_rdy_o, lsb_rdy_o}); end
    for (int i = 0; i < 3; i++) begin
      step();
      expect_bc("flush_quiet", 1'b0, 4'd0, 1'b0);
    end
    alu(4'd8, 32'h8); lsb(4'd9, 32'h9);
    step();
    idle_in();
    step();
    expect_bc("flush_rr_first", 1'b1, 4'd8, 1'b0);
    step();
    expect_bc("flush_rr_second", 1'b1, 4'd9, 1'b1);
  endtask
  task automatic test_en_hold;
    do_reset();
    alu(4'd5, 32'h55);
    step();
    alu(4'd6, 32'h66);
    step();
    expect_bc("hold_pre", 1'b1, 4'd5, 1'b0);
    idle_in();
    en = 1'b0;
    alu(4'd7, 32'h77);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_bc("hold_frozen", 1'b1, 4'd5, 1'b0);
      cmp++; if (cdb_v_o !== 32'h55) begin bad++; $display("FAIL hold_v[%0d] got %0h want 55", i, cdb_v_o); end
    end
    idle_in();
    step();
    expect_bc("hold_resume", 1'b1, 4'd6, 1'b0);
    step();
    expect_bc("hold_dropped", 1'b0, 4'd0, 1'b0);
  endtask
  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_flush();
    test_en_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
